// File: rtl/median_window_controller.sv
// ----------------------------------------------------------------------------
// median_window_controller
//
// Sequencer in front of a chain of median middle actors. For each window it
// pushes one atomic set of configuration tokens (pivot, buffer size, median
// position, second median value) into the chain head, streams exactly
// WIN_SIZE pixels from the source FIFO into the chain, then waits for the
// chain's median and forwards it to the result FIFO. Only one window is in
// flight, so tokens can never overtake or trail their pixels.
//
// Optional feature (macro MEDIAN_CTRL_TIMEOUT_EN):
//   A WAIT-state watchdog. After TIMEOUT_CYCLES WAIT cycles without a result,
//   DEFAULT_PIVOT is written as the median, the sticky error flag is set and
//   the next window starts. Without the macro WAIT lasts indefinitely and
//   error is tied low.
//
// Ports:
//   clock, reset                   clock / asynchronous active-low reset
//   in_px, in_px_rd, in_px_empty   source pixel FIFO (read side)
//   out_px*                        chain pixel FIFO (write side)
//   out_pivot*, out_buff_size*,
//   out_median_pos*,
//   out_second_median_value*       chain configuration token FIFOs
//   res_median*                    chain result FIFO (read side)
//   median*                        result FIFO (write side)
//   busy                           state is not IDLE
//   win_cnt                        completed windows (wrapping)
//   error                          sticky watchdog timeout flag
// ----------------------------------------------------------------------------
module median_window_controller #(
    parameter logic [10:0] WIN_SIZE      = 11'd9,
    parameter logic [9:0]  MEDIAN_POS    = 10'd4,
    parameter int unsigned BUFF_SIZE_BIT = $clog2(WIN_SIZE) + 1,
    parameter logic [7:0]  DEFAULT_PIVOT = 8'd127
`ifdef MEDIAN_CTRL_TIMEOUT_EN
   ,parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096
`endif
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [7:0]               in_px,
    output logic                     in_px_rd,
    input  logic                     in_px_empty,
    output logic [7:0]               out_px,
    output logic                     out_px_wr,
    input  logic                     out_px_full,
    output logic [7:0]               out_pivot,
    output logic                     out_pivot_wr,
    input  logic                     out_pivot_full,
    output logic [BUFF_SIZE_BIT-1:0] out_buff_size,
    output logic                     out_buff_size_wr,
    input  logic                     out_buff_size_full,
    output logic [BUFF_SIZE_BIT-1:0] out_median_pos,
    output logic                     out_median_pos_wr,
    input  logic                     out_median_pos_full,
    output logic [7:0]               out_second_median_value,
    output logic                     out_second_median_value_wr,
    input  logic                     out_second_median_value_full,
    input  logic [7:0]               res_median,
    output logic                     res_median_rd,
    input  logic                     res_median_empty,
    output logic [7:0]               median,
    output logic                     median_wr,
    input  logic                     median_full,
    output logic                     busy,
    output logic [15:0]              win_cnt,
    output logic                     error
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CFG    = 2'd1,
        STREAM = 2'd2,
        WAIT   = 2'd3
    } state_t;

    localparam logic [BUFF_SIZE_BIT-1:0] PX_ONE  = {{(BUFF_SIZE_BIT-1){1'b0}}, 1'b1};
    localparam logic [BUFF_SIZE_BIT-1:0] LAST_PX = WIN_SIZE[BUFF_SIZE_BIT-1:0] - PX_ONE;

    state_t                   state_q, state_d;
    logic [BUFF_SIZE_BIT-1:0] px_cnt_q, px_cnt_d;
    logic [15:0]              win_cnt_q, win_cnt_d;

`ifdef MEDIAN_CTRL_TIMEOUT_EN
    logic [15:0] wd_q, wd_d;
    logic        err_q, err_d;
    logic        timeout_fire;
`endif

    // Constant token data and pass-through datapaths
    assign out_pivot               = DEFAULT_PIVOT;
    assign out_buff_size           = WIN_SIZE[BUFF_SIZE_BIT-1:0];
    assign out_median_pos          = MEDIAN_POS[BUFF_SIZE_BIT-1:0];
    assign out_second_median_value = DEFAULT_PIVOT;
    assign out_px                  = in_px;

    assign busy    = (state_q != IDLE);
    assign win_cnt = win_cnt_q;
`ifdef MEDIAN_CTRL_TIMEOUT_EN
    assign error   = err_q;
`else
    assign error   = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            px_cnt_q  <= '0;
            win_cnt_q <= '0;
`ifdef MEDIAN_CTRL_TIMEOUT_EN
            wd_q      <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            px_cnt_q  <= px_cnt_d;
            win_cnt_q <= win_cnt_d;
`ifdef MEDIAN_CTRL_TIMEOUT_EN
            wd_q      <= wd_d;
            err_q     <= err_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        px_cnt_d  = px_cnt_q;
        win_cnt_d = win_cnt_q;
        case (state_q)
            IDLE: state_d = CFG;
            CFG: begin
                if (out_pivot_wr) begin
                    state_d  = STREAM;
                    px_cnt_d = '0;
                end
            end
            STREAM: begin
                if (out_px_wr) begin
                    if (px_cnt_q == LAST_PX) begin
                        state_d  = WAIT;
                        px_cnt_d = '0;
                    end else begin
                        px_cnt_d = px_cnt_q + PX_ONE;
                    end
                end
            end
            WAIT: begin
                // median_wr covers both a real result and a watchdog result
                if (median_wr) begin
                    win_cnt_d = win_cnt_q + 16'd1;
                    state_d   = CFG;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef MEDIAN_CTRL_TIMEOUT_EN
        // Held at zero outside WAIT so it is already clear on WAIT entry;
        // saturates at the limit while median_full blocks the timeout write.
        wd_d  = '0;
        err_d = err_q | timeout_fire;
        if (state_q == WAIT && !median_wr) begin
            wd_d = (wd_q >= TIMEOUT_CYCLES) ? wd_q : wd_q + 16'd1;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        in_px_rd                   = 1'b0;
        out_px_wr                  = 1'b0;
        out_pivot_wr               = 1'b0;
        out_buff_size_wr           = 1'b0;
        out_median_pos_wr          = 1'b0;
        out_second_median_value_wr = 1'b0;
        res_median_rd              = 1'b0;
        median_wr                  = 1'b0;
        median                     = res_median;
`ifdef MEDIAN_CTRL_TIMEOUT_EN
        timeout_fire               = 1'b0;
`endif
        case (state_q)
            CFG: begin
                // All four tokens go together or not at all
                if (!(out_pivot_full | out_buff_size_full |
                      out_median_pos_full | out_second_median_value_full)) begin
                    out_pivot_wr               = 1'b1;
                    out_buff_size_wr           = 1'b1;
                    out_median_pos_wr          = 1'b1;
                    out_second_median_value_wr = 1'b1;
                end
            end
            STREAM: begin
                if (!in_px_empty && !out_px_full) begin
                    in_px_rd  = 1'b1;
                    out_px_wr = 1'b1;
                end
            end
            WAIT: begin
                if (!res_median_empty && !median_full) begin
                    res_median_rd = 1'b1;
                    median_wr     = 1'b1;
                end
`ifdef MEDIAN_CTRL_TIMEOUT_EN
                else if (wd_q >= TIMEOUT_CYCLES && !median_full) begin
                    median       = DEFAULT_PIVOT;
                    median_wr    = 1'b1;
                    timeout_fire = 1'b1;
                end
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_median_window_controller.sv
// ----------------------------------------------------------------------------
// Scoreboard bench for median_window_controller. Stimulus pushes expected
// tokens / pixels / medians into queues; a negedge monitor pops and compares
// whenever the DUT writes. Directed checks cover stalls, ordering and reset.
// ----------------------------------------------------------------------------
module tb_median_window_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  in_px;
    logic        in_px_rd, in_px_empty;
    logic [7:0]  out_px;
    logic        out_px_wr, out_px_full;
    logic [7:0]  out_pivot;
    logic        out_pivot_wr, out_pivot_full;
    logic [4:0]  out_buff_size;
    logic        out_buff_size_wr, out_buff_size_full;
    logic [4:0]  out_median_pos;
    logic        out_median_pos_wr, out_median_pos_full;
    logic [7:0]  out_second_median_value;
    logic        out_second_median_value_wr, out_second_median_value_full;
    logic [7:0]  res_median;
    logic        res_median_rd, res_median_empty;
    logic [7:0]  median;
    logic        median_wr, median_full;
    logic        busy;
    logic [15:0] win_cnt;
    logic        error;

    always #5 clock = ~clock;

    median_window_controller #(
`ifdef MEDIAN_CTRL_TIMEOUT_EN
        .TIMEOUT_CYCLES(16'd16),
`endif
        .WIN_SIZE(11'd9),
        .MEDIAN_POS(10'd4),
        .BUFF_SIZE_BIT(5),
        .DEFAULT_PIVOT(8'd127)
    ) dut (
        .clock(clock), .reset(reset),
        .in_px(in_px), .in_px_rd(in_px_rd), .in_px_empty(in_px_empty),
        .out_px(out_px), .out_px_wr(out_px_wr), .out_px_full(out_px_full),
        .out_pivot(out_pivot), .out_pivot_wr(out_pivot_wr), .out_pivot_full(out_pivot_full),
        .out_buff_size(out_buff_size), .out_buff_size_wr(out_buff_size_wr),
        .out_buff_size_full(out_buff_size_full),
        .out_median_pos(out_median_pos), .out_median_pos_wr(out_median_pos_wr),
        .out_median_pos_full(out_median_pos_full),
        .out_second_median_value(out_second_median_value),
        .out_second_median_value_wr(out_second_median_value_wr),
        .out_second_median_value_full(out_second_median_value_full),
        .res_median(res_median), .res_median_rd(res_median_rd),
        .res_median_empty(res_median_empty),
        .median(median), .median_wr(median_wr), .median_full(median_full),
        .busy(busy), .win_cnt(win_cnt), .error(error)
    );

    typedef struct packed {
        logic [7:0]  val;
        logic        rd;
        logic [15:0] win;
    } med_t;

    localparam logic [25:0] TOK = {8'd127, 5'd9, 5'd4, 8'd127};

    logic [7:0]  src_q[$];
    logic [7:0]  res_q[$];
    logic [7:0]  exp_px[$];
    logic [25:0] exp_tok[$];
    med_t        exp_med[$];

    int checks   = 0;
    int failures = 0;

    logic last_px, last_res, last_tok, last_med;
    logic [7:0] strobes;
    assign strobes = {in_px_rd, out_px_wr, out_pivot_wr, out_buff_size_wr,
                      out_median_pos_wr, out_second_median_value_wr,
                      res_median_rd, median_wr};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    function automatic med_t mk_med(input logic [7:0] v, input logic rd, input logic [15:0] w);
        med_t m;
        m.val = v;
        m.rd  = rd;
        m.win = w;
        return m;
    endfunction

    task automatic apply_inputs();
        in_px            = (src_q.size() > 0) ? src_q[0] : 8'h00;
        in_px_empty      = (src_q.size() == 0);
        res_median       = (res_q.size() > 0) ? res_q[0] : 8'h00;
        res_median_empty = (res_q.size() == 0);
    endtask

    // One clock: sample strobes mid-cycle, then let the FIFO models react
    task automatic cycle();
        @(negedge clock);
        last_px  = in_px_rd;
        last_res = res_median_rd;
        last_tok = out_pivot_wr;
        last_med = median_wr;
        @(posedge clock);
        #1;
        if (last_px && src_q.size() > 0) void'(src_q.pop_front());
        if (last_res && res_q.size() > 0) void'(res_q.pop_front());
        apply_inputs();
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic        pend = 1'b0;
    logic [15:0] pend_win;
    logic [25:0] t_tok;
    logic [7:0]  t_px;
    med_t        t_med;

    always @(negedge clock) begin
        if (!reset) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                chk("win_cnt_after_result", win_cnt, pend_win);
                pend = 1'b0;
            end
            if (out_pivot_wr | out_buff_size_wr | out_median_pos_wr | out_second_median_value_wr) begin
                chk("tok_atomic", {out_pivot_wr, out_buff_size_wr, out_median_pos_wr,
                                   out_second_median_value_wr}, 4'hF);
                if (exp_tok.size() == 0) chk("tok_unexpected", 1, 0);
                else begin
                    t_tok = exp_tok.pop_front();
                    chk("tok_values", {out_pivot, out_buff_size, out_median_pos,
                                       out_second_median_value}, t_tok);
                end
            end
            if (out_px_wr | in_px_rd) begin
                chk("px_rd_eq_wr", in_px_rd, out_px_wr);
                if (exp_px.size() == 0) chk("px_unexpected", 1, 0);
                else begin
                    t_px = exp_px.pop_front();
                    chk("px_data", out_px, t_px);
                end
            end
            if (median_wr) begin
                if (exp_med.size() == 0) chk("median_unexpected", 1, 0);
                else begin
                    t_med = exp_med.pop_front();
                    chk("median_data", median, t_med.val);
                    chk("median_rd", res_median_rd, t_med.rd);
                    pend     = 1'b1;
                    pend_win = t_med.win;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    int n;
    int bad;
    int k;
    logic seen;

    initial begin
        out_px_full = 0; out_pivot_full = 0; out_buff_size_full = 0;
        out_median_pos_full = 0; out_second_median_value_full = 0; median_full = 0;
        apply_inputs();

        #12;
        chk("rst_strobes", strobes, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_win_cnt", win_cnt, 0);
        chk("rst_error", error, 0);

        // Window 1: clean stream, 10th pixel must stay in the source
        foreach (src_q[i]) ;
        src_q = '{8'd5, 8'd1, 8'd9, 8'd3, 8'd7, 8'd2, 8'd8, 8'd4, 8'd6, 8'd11};
        exp_px = '{8'd5, 8'd1, 8'd9, 8'd3, 8'd7, 8'd2, 8'd8, 8'd4, 8'd6};
        exp_tok.push_back(TOK);
        apply_inputs();
        @(posedge clock); #1 reset = 1'b1;

        n = 0;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (last_px) n++;
            else if (n > 0) break;
        end
        chk("w1_consecutive_px", n, 9);
        repeat (3) cycle();
        chk("w1_10th_not_read", src_q.size(), 1);
        chk("w1_busy_in_wait", busy, 1);

        // Result 5 blocked by median_full for two cycles
        out_px_full = 1; median_full = 1;
        res_q.push_back(8'd5);
        exp_med.push_back(mk_med(8'd5, 1'b1, 16'd1));
        exp_tok.push_back(TOK);
        apply_inputs();
        cycle(); chk("res_stall1", {last_med, last_res}, 2'b00);
        cycle(); chk("res_stall2", {last_med, last_res}, 2'b00);
        median_full = 0;
        cycle(); chk("res_fwd", last_med, 1);
        cycle(); chk("cfg_after_res", last_tok, 1);

        // Window 2: out_px_full toggles every other cycle
        for (int v = 20; v < 28; v++) src_q.push_back(8'(v));
        src_q.push_back(8'd99);
        exp_px.push_back(8'd11);
        for (int v = 20; v < 28; v++) exp_px.push_back(8'(v));
        apply_inputs();
        n = 0; bad = 0;
        for (int i = 0; i < 30; i++) begin
            out_px_full = (i % 2 == 1);
            cycle();
            if (last_px) n++;
            if (last_px && out_px_full) bad++;
        end
        chk("w2_xfers", n, 9);
        chk("w2_no_rd_on_full", bad, 0);
        chk("w2_leftover", src_q.size(), 1);

        // CFG blocked by out_median_pos_full for three cycles
        out_px_full = 1; out_median_pos_full = 1;
        res_q.push_back(8'd9);
        exp_med.push_back(mk_med(8'd9, 1'b1, 16'd2));
        exp_tok.push_back(TOK);
        apply_inputs();
        cycle(); chk("w2_res_fwd", last_med, 1);
        for (int i = 0; i < 3; i++) begin
            cycle(); chk("cfg_hold_full", last_tok, 0);
        end
        out_median_pos_full = 0;
        cycle(); chk("cfg_release", last_tok, 1);

        // Window 3: reset after four pixels
        for (int v = 30; v < 38; v++) src_q.push_back(8'(v));
        exp_px = '{8'd99, 8'd30, 8'd31, 8'd32};
        out_px_full = 0;
        apply_inputs();
        n = 0;
        repeat (4) begin cycle(); if (last_px) n++; end
        chk("w3_partial", n, 4);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_strobes", strobes, 8'h00);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_win_cnt", win_cnt, 0);
        chk("exp_px_drained_before_reset", exp_px.size(), 0);
        src_q.delete(); res_q.delete();

        // Fresh start after reset
        for (int v = 40; v < 49; v++) begin
            src_q.push_back(8'(v));
            exp_px.push_back(8'(v));
        end
        exp_tok.push_back(TOK);
        apply_inputs();
        @(posedge clock); #1;
        @(posedge clock); #1 reset = 1'b1;
        cycle(); chk("post_rst_idle", last_tok, 0);
        cycle(); chk("post_rst_cfg", last_tok, 1);
        chk("post_rst_win_cnt", win_cnt, 0);
        n = 0;
        for (int i = 0; i < 20 && n < 9; i++) begin
            cycle();
            if (last_px) n++;
        end
        chk("w4_xfers", n, 9);

`ifdef MEDIAN_CTRL_TIMEOUT_EN
        exp_med.push_back(mk_med(8'd127, 1'b0, 16'd1));
        exp_tok.push_back(TOK);
        k = 0;
        for (int i = 0; i < 100; i++) begin
            cycle();
            k++;
            if (last_med) break;
        end
        chk("timeout_latency", k, 17);
        chk("timeout_error", error, 1);
        cycle();
        chk("timeout_win_cnt", win_cnt, 1);
`else
        seen = 1'b0;
        repeat (40) begin
            cycle();
            if (last_med) seen = 1'b1;
        end
        chk("no_timeout_median", seen, 0);
        chk("no_timeout_error", error, 0);
        chk("no_timeout_busy", busy, 1);
`endif

        repeat (3) cycle();
        chk("drain_px", exp_px.size(), 0);
        chk("drain_tok", exp_tok.size(), 0);
        chk("drain_med", exp_med.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the bench always ends
    initial begin
        #200000;
        failures++;
        $display("FAIL global_timeout got=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/median_window_controller.md
Name: median_window_controller

Overview:
- Sequencer in front of a chain of median middle actors.
- For every window it pushes one configuration token set (pivot, buffer size, median position, second median value) into the chain's head FIFOs, then streams exactly WIN_SIZE pixels from a source FIFO into the chain.
- It then waits for the chain's median result and forwards it to a result FIFO.
- One window is in flight at a time, so configuration tokens can never be reordered with respect to their pixels.

Parameters:
WIN_SIZE, 11'd9, pixels per window; valid range 1..2^BUFF_SIZE_BIT-1.
MEDIAN_POS, 10'd4, median position token sent with each window.
BUFF_SIZE_BIT, $clog2(WIN_SIZE)+1, width of the buffer-size and median-position tokens.
DEFAULT_PIVOT, 8'd127, pivot and second-median token value; also the timeout result.
TIMEOUT_CYCLES, 16'd4096, watchdog limit in WAIT; used only with the optional feature.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous active-low reset
in_px  in  8  source pixel
in_px_rd  out  1  source pop
in_px_empty  in  1  source empty
out_px  out  8  pixel to chain
out_px_wr  out  1  push pixel
out_px_full  in  1  chain pixel FIFO full
out_pivot  out  8  pivot token
out_pivot_wr  out  1  push pivot
out_pivot_full  in  1  full
out_buff_size  out  BUFF_SIZE_BIT  buffer-size token
out_buff_size_wr  out  1  push
out_buff_size_full  in  1  full
out_median_pos  out  BUFF_SIZE_BIT  median-position token
out_median_pos_wr  out  1  push
out_median_pos_full  in  1  full
out_second_median_value  out  8  second-median token
out_second_median_value_wr  out  1  push
out_second_median_value_full  in  1  full
res_median  in  8  median from chain tail
res_median_rd  out  1  pop result
res_median_empty  in  1  result empty
median  out  8  forwarded result
median_wr  out  1  push result
median_full  in  1  result FIFO full
busy  out  1  high when state is not IDLE
win_cnt  out  16  completed windows, wraps at 16'hFFFF->0
error  out  1  sticky timeout flag; constant 0 without the optional feature

Behaviour:
Clock and reset:
- Single clock `clock`. `reset` is asynchronous and active-low.
- On reset: state=IDLE; px_cnt=0; win_cnt=0; error=0; all *_wr and *_rd outputs 0.
- Reset mid-window aborts the window immediately. No partial token flush; upstream FIFOs are reset by the same signal.

Token outputs:
- Constant data: out_pivot=DEFAULT_PIVOT, out_buff_size=WIN_SIZE[BUFF_SIZE_BIT-1:0], out_median_pos=MEDIAN_POS[BUFF_SIZE_BIT-1:0], out_second_median_value=DEFAULT_PIVOT.

FSM:
- IDLE: go to CFG the cycle after reset release.
- CFG: all four token writes assert together, same cycle, combinationally, only when all four fulls are 0 (atomic push). Then go to STREAM with px_cnt=0. If any full is 1, no write and stay in CFG.
- STREAM:
  - Pass-through: out_px=in_px combinationally. xfer = ~in_px_empty & ~out_px_full. in_px_rd = out_px_wr = xfer.
  - Zero added latency; one pixel per cycle max.
  - px_cnt increments on xfer. On the xfer with px_cnt==WIN_SIZE-1, go to WAIT and clear px_cnt.
  - Stalls on either side hold px_cnt.
- WAIT:
  - Pass-through: median=res_median. fwd = ~res_median_empty & ~median_full. res_median_rd = median_wr = fwd.
  - On fwd: win_cnt+1, go to CFG.
  - Pixels arriving during WAIT/CFG are not read.
- Simultaneous events: in STREAM, an input arriving while the output is full is not consumed; neither read nor write fires.

Optional Feature:
Macro MEDIAN_CTRL_TIMEOUT_EN.
- Defined:
  - 16-bit watchdog clears on WAIT entry and increments each WAIT cycle without fwd.
  - On reaching TIMEOUT_CYCLES with median_full=0: median=DEFAULT_PIVOT, median_wr=1, res_median_rd=0, error<=1 (sticky until reset), win_cnt+1, go to CFG.
  - A later stale result is consumed as the next window's median; this is accepted behaviour.
- Undefined: no watchdog; WAIT lasts indefinitely; error tied to 0.

Test Plan:
- Reset release, all FIFOs ready, 9 pixels {5,1,9,3,7,2,8,4,6} available -> CFG writes tokens (127, 9, 4, 127) once. 9 pixel writes occur on consecutive cycles with out_px matching in order. 10th pixel not read.
- out_median_pos_full=1 for 3 cycles in CFG -> no token write at all during those cycles; all four write together on the 4th cycle.
- out_px_full toggles every other cycle during STREAM -> exactly 9 pixel xfers, no duplicates or losses, px_cnt held on stalls.
- Result 8'd5 arrives with median_full=1 for 2 cycles -> median_wr fires once when full drops, median=5, win_cnt 0->1, next CFG tokens written the following cycle.
- Reset asserted after 4 pixels streamed -> all outputs 0 asynchronously. After release, a fresh CFG occurs and win_cnt=0.
- MEDIAN_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=16, no result -> after 16 WAIT cycles median=127 with median_wr=1, error=1, win_cnt=1.
